// File: rtl/mac_learn_lookup.sv
// rtl/mac_learn_lookup.sv - learning-switch MAC table: learn source, look up destination, present port bitmap
//
// Purpose:
//   Sits behind the Ethernet header parser. On a rising edge of i_eth_done it
//   latches dst/src MAC and ingress port. It then scans the table one entry per
//   cycle, learns src_mac->src_port, and presents a forwarding bitmap under a
//   valid/ack handshake.
//
// Ports:
//   i_clk            clock
//   i_reset          asynchronous reset, active low
//   i_dst_mac        destination MAC from parser (stable while i_eth_done)
//   i_src_mac        source MAC from parser
//   i_src_port       ingress port index
//   i_eth_done       parser header-ready level
//   i_lookup_ack     consumer has taken the current result
//   i_table_flush    single-cycle pulse, invalidates every entry
//   o_dst_ports      forwarding bitmap, bit p = output port p
//   o_lookup_hit     destination MAC found in the table
//   o_lookup_valid   o_dst_ports/o_lookup_hit valid, held until ack
//   o_req_dropped    one-cycle pulse when a start arrives while busy
module mac_learn_lookup #(
  parameter int NUM_IQ_BITS       = 3,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int LUT_DEPTH         = 8,
  parameter int LUT_DEPTH_BITS    = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [47:0]                  i_dst_mac,
  input  logic [47:0]                  i_src_mac,
  input  logic [NUM_IQ_BITS-1:0]       i_src_port,
  input  logic                         i_eth_done,
  input  logic                         i_lookup_ack,
  input  logic                         i_table_flush,
  output logic [NUM_OUTPUT_QUEUES-1:0] o_dst_ports,
  output logic                         o_lookup_hit,
  output logic                         o_lookup_valid,
  output logic                         o_req_dropped
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_LEARN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Table storage. Only the valid bits need reset; MAC/port are don't-care while invalid.
  logic [LUT_DEPTH-1:0]      r_valid;
  logic [47:0]               r_mac  [LUT_DEPTH];
  logic [NUM_IQ_BITS-1:0]    r_port [LUT_DEPTH];
  logic [LUT_DEPTH_BITS-1:0] r_victim;

  // Latched request
  logic                      r_eth_done_d;
  logic [47:0]               r_dst_mac;
  logic [47:0]               r_src_mac;
  logic [NUM_IQ_BITS-1:0]    r_src_port;

  // Search progress and first-match records
  logic [LUT_DEPTH_BITS-1:0] r_idx;
  logic                      r_dst_hit;
  logic [NUM_IQ_BITS-1:0]    r_dst_port;
  logic                      r_src_hit;
  logic [LUT_DEPTH_BITS-1:0] r_src_idx;
  logic                      r_free_found;
  logic [LUT_DEPTH_BITS-1:0] r_free_idx;

  // Output registers
  logic [NUM_OUTPUT_QUEUES-1:0] r_dst_ports;
  logic                         r_lookup_hit;
  logic                         r_lookup_valid;
  logic                         r_req_dropped;

  logic                         w_start;
  logic                         w_last;
  logic                         w_dst_match;
  logic                         w_src_match;
  logic                         w_learn;
  logic                         w_victim_adv;
  logic [LUT_DEPTH_BITS-1:0]    w_wr_idx;
  logic [NUM_OUTPUT_QUEUES-1:0] w_flood;
  logic [NUM_OUTPUT_QUEUES-1:0] w_res_ports;
  logic                         w_res_hit;

  assign w_start     = i_eth_done & ~r_eth_done_d;
  assign w_last      = (r_idx == LUT_DEPTH_BITS'(LUT_DEPTH - 1));
  assign w_dst_match = r_valid[r_idx] & (r_mac[r_idx] == r_dst_mac);
  assign w_src_match = r_valid[r_idx] & (r_mac[r_idx] == r_src_mac);

  // Multicast sources are never learned; a flush in LEARN cancels the write.
  assign w_learn      = (r_state == S_LEARN) & ~i_table_flush & ~r_src_mac[40];
  assign w_wr_idx     = r_src_hit    ? r_src_idx  :
                        r_free_found ? r_free_idx : r_victim;
  assign w_victim_adv = w_learn & ~r_src_hit & ~r_free_found;

  // Flood to every port except the one the frame arrived on.
  assign w_flood = ~(NUM_OUTPUT_QUEUES'(1) << r_src_port);

  always_comb begin
    w_res_ports = w_flood;
    w_res_hit   = 1'b0;
    if (!r_dst_mac[40] && r_dst_hit) begin
      w_res_hit = 1'b1;
      if (r_dst_port == r_src_port) begin
        w_res_ports = '0;
      end else begin
        w_res_ports = NUM_OUTPUT_QUEUES'(1) << r_dst_port;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_SEARCH;
      S_SEARCH: if (w_last) w_state_nxt = S_LEARN;
      S_LEARN:  w_state_nxt = S_RESULT;
      S_RESULT: if (i_lookup_ack) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    // A flush aborts any request that has not yet produced a result.
    if (i_table_flush && (r_state != S_RESULT)) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Table MAC/port storage
  always_ff @(posedge i_clk) begin
    if (w_learn) begin
      r_mac[w_wr_idx]  <= r_src_mac;
      r_port[w_wr_idx] <= r_src_port;
    end
  end

  // Table valid bits and replacement pointer
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid  <= '0;
      r_victim <= '0;
    end else if (i_table_flush) begin
      r_valid  <= '0;
      r_victim <= '0;
    end else begin
      if (w_learn) begin
        r_valid[w_wr_idx] <= 1'b1;
      end
      if (w_victim_adv) begin
        r_victim <= r_victim + LUT_DEPTH_BITS'(1);
      end
    end
  end

  // Request latch, search bookkeeping and outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_eth_done_d   <= 1'b0;
      r_dst_mac      <= '0;
      r_src_mac      <= '0;
      r_src_port     <= '0;
      r_idx          <= '0;
      r_dst_hit      <= 1'b0;
      r_dst_port     <= '0;
      r_src_hit      <= 1'b0;
      r_src_idx      <= '0;
      r_free_found   <= 1'b0;
      r_free_idx     <= '0;
      r_dst_ports    <= '0;
      r_lookup_hit   <= 1'b0;
      r_lookup_valid <= 1'b0;
      r_req_dropped  <= 1'b0;
    end else begin
      r_eth_done_d  <= i_eth_done;
      r_req_dropped <= w_start & (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_start && !i_table_flush) begin
            r_dst_mac    <= i_dst_mac;
            r_src_mac    <= i_src_mac;
            r_src_port   <= i_src_port;
            r_idx        <= '0;
            r_dst_hit    <= 1'b0;
            r_src_hit    <= 1'b0;
            r_free_found <= 1'b0;
          end
        end
        S_SEARCH: begin
          r_idx <= r_idx + LUT_DEPTH_BITS'(1);
          if (w_dst_match && !r_dst_hit) begin
            r_dst_hit  <= 1'b1;
            r_dst_port <= r_port[r_idx];
          end
          if (w_src_match && !r_src_hit) begin
            r_src_hit <= 1'b1;
            r_src_idx <= r_idx;
          end
          if (!r_valid[r_idx] && !r_free_found) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
        end
        S_LEARN: begin
          if (!i_table_flush) begin
            r_dst_ports    <= w_res_ports;
            r_lookup_hit   <= w_res_hit;
            r_lookup_valid <= 1'b1;
          end
        end
        S_RESULT: begin
          if (i_lookup_ack) begin
            r_dst_ports    <= '0;
            r_lookup_hit   <= 1'b0;
            r_lookup_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dst_ports    = r_dst_ports;
  assign o_lookup_hit   = r_lookup_hit;
  assign o_lookup_valid = r_lookup_valid;
  assign o_req_dropped  = r_req_dropped;

endmodule
